// File: rtl/morse_char_seq_if.sv
// Interface between the Morse character sequencer, its character source,
// the transmit bit mux and the message-level controller.
//   start/abort/patron/longitud : character request from the controller/encoder
//   entrada/sel                 : latched pattern and select toward the bit mux
//   salida                      : selected bit returned by the mux
//   tx_out/busy/done            : key line and status back to the controller
// master: drives requests and the mux result; slave: the sequencer itself.
interface morse_char_seq_if;
    localparam int unsigned DATA_W = 22;
    localparam int unsigned SEL_W  = 5;

    logic              start;
    logic              abort;
    logic [DATA_W-1:0] patron;
    logic [SEL_W-1:0]  longitud;
    logic [DATA_W-1:0] entrada;
    logic [SEL_W-1:0]  sel;
    logic              salida;
    logic              tx_out;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, patron, longitud, salida,
        input  entrada, sel, tx_out, busy, done
    );

    modport slave (
        input  start, abort, patron, longitud, salida,
        output entrada, sel, tx_out, busy, done
    );
endinterface

// File: rtl/morse_char_seq.sv
// Morse character sequencer: latches one character pattern and its length,
// walks the 22-bit/5-bit-select bit mux one position per Morse unit and
// registers the mux output as the key line.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : morse_char_seq_if.slave (start/abort/patron/longitud in,
//            entrada/sel to the mux, salida from the mux,
//            tx_out/busy/done out)
// Parameters: UNIT_CYCLES (clocks per unit, >= 2), CNT_W (unit counter width),
//             GAP_UNITS (inter-character gap, used with MORSE_GAP_EN).
// Optional feature macro: MORSE_GAP_EN adds a silent GAP state of GAP_UNITS
// units after the last unit, before done is pulsed.
module morse_char_seq #(
    parameter int unsigned UNIT_CYCLES = 12000000,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned GAP_UNITS   = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    morse_char_seq_if.slave bus
);

    localparam int unsigned DATA_W = 22;
    localparam int unsigned SEL_W  = 5;
    localparam logic [SEL_W-1:0] MAX_LEN  = SEL_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UNIT_CYCLES - 1);

`ifdef MORSE_GAP_EN
    localparam int unsigned GAP_W = (GAP_UNITS > 1) ? $clog2(GAP_UNITS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_UNITS - 1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1
`ifdef MORSE_GAP_EN
        ,
        GAP  = 2'd2
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] entrada_q, entrada_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef MORSE_GAP_EN
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              gap_done_c;
`else
    logic              unused_gap_cfg;
    assign unused_gap_cfg = ^32'(GAP_UNITS);
`endif

    logic unit_end_c;
    logic last_unit_c;
    logic accept_c;

    // Event decode shared by the next-state and output logic.
    assign unit_end_c  = (cnt_q == CNT_LAST);
    assign last_unit_c = (sel_q == (len_q - SEL_W'(1)));
    assign accept_c    = (state_q == IDLE) && bus.start && (bus.longitud != '0);
`ifdef MORSE_GAP_EN
    assign gap_done_c  = unit_end_c && (gap_q == GAP_LAST);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort wins over a same-cycle unit end.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (unit_end_c && last_unit_c) begin
`ifdef MORSE_GAP_EN
                    state_d = GAP;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef MORSE_GAP_EN
            GAP: begin
                if (bus.abort || gap_done_c) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        len_d     = len_q;
        entrada_d = entrada_q;
        tx_d      = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef MORSE_GAP_EN
        gap_d     = gap_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    entrada_d = bus.patron;
                    len_d     = (bus.longitud > MAX_LEN) ? MAX_LEN : bus.longitud;
                    sel_d     = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
`ifdef MORSE_GAP_EN
                    gap_d     = '0;
`endif
                end
            end
            SEND: begin
                if (bus.abort) begin
                    cnt_d  = '0;
                    sel_d  = '0;
                    busy_d = 1'b0;
                end else begin
                    // Key line trails sel by one cycle, so each unit is
                    // exactly UNIT_CYCLES wide on tx_out.
                    tx_d  = bus.salida;
                    cnt_d = unit_end_c ? '0 : cnt_q + CNT_W'(1);
                    if (unit_end_c) begin
                        if (!last_unit_c) begin
                            sel_d = sel_q + SEL_W'(1);
                        end else begin
                            sel_d = '0;
`ifdef MORSE_GAP_EN
                            gap_d = '0;
`else
                            busy_d = 1'b0;
                            done_d = 1'b1;
`endif
                        end
                    end
                end
            end
`ifdef MORSE_GAP_EN
            GAP: begin
                if (bus.abort) begin
                    cnt_d  = '0;
                    busy_d = 1'b0;
                end else begin
                    cnt_d = unit_end_c ? '0 : cnt_q + CNT_W'(1);
                    if (gap_done_c) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else if (unit_end_c) begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
            end
`endif
            default: begin
                cnt_d  = '0;
                sel_d  = '0;
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            sel_q     <= '0;
            len_q     <= '0;
            entrada_q <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MORSE_GAP_EN
            gap_q     <= '0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            len_q     <= len_d;
            entrada_q <= entrada_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef MORSE_GAP_EN
            gap_q     <= gap_d;
`endif
        end
    end

    assign bus.entrada = entrada_q;
    assign bus.sel     = sel_q;
    assign bus.tx_out  = tx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule
